data_stack: RTL and testbench

DATA_STACK -- requirements
Module: data_stack

---
 rtl/data_stack.sv | 73 +++++++
 tb/tb_data_stack.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// LIFO operand stack: register-array storage addressed by a stack pointer that doubles as depth.
// Exposes the two topmost entries and a sticky overflow/underflow error flag.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PW    = 5
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [PW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic             err_q;

  logic [AW-1:0] top_idx;
  logic [AW-1:0] next_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;
  logic          bad_op;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign top_idx  = AW'(sp - PW'(1));
  assign next_idx = AW'(sp - PW'(2));
  assign empty    = (sp == '0);
  assign full     = (sp == PW'(DEPTH));

  // NOTE: every signal assigned here gets a value on every path, so no latches are inferred.
  always_comb begin
    do_push = push & ~pop & ~full;
    do_pop  = pop & ~push & ~empty;
    do_repl = push & pop & ~empty;
    bad_op  = (pop & empty) | (push & ~pop & full);
    wr_en   = (do_push | do_repl) & rst_n;
    wr_addr = do_repl ? top_idx : sp[AW-1:0];
  end

  // NOTE: storage is deliberately not reset; entries at or above sp are masked off the outputs.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      if (do_push)     sp <= sp + PW'(1);
      else if (do_pop) sp <= sp - PW'(1);
      if (bad_op) err_q <= 1'b1;
    end
  end

  assign top   = (sp != '0)        ? mem[top_idx]  : '0;
  assign next  = (sp >= PW'(2))    ? mem[next_idx] : '0;
  assign depth = sp;
  assign err   = err_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: a queue-based stack model predicts each cycle's outputs,
// which are queued at drive time and compared after the clock edge.
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  typedef struct {
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nxt;
    logic [PW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             err;
  } exp_t;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [PW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             err;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .top   (top),
    .next  (next),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  always #5 CLK = ~CLK;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [WIDTH-1:0] model[$];
  logic             model_err;
  exp_t             sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int n = model.size();
    e.top   = (n >= 1) ? model[n-1] : '0;
    e.nxt   = (n >= 2) ? model[n-2] : '0;
    e.depth = PW'(n);
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.err   = model_err;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    n_asserts++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed depth 0x%0h expected an entry", tag, depth);
      return;
    end
    e = sb.pop_front();
    check({tag, ".top"},   32'(top),   32'(e.top));
    check({tag, ".next"},  32'(next),  32'(e.nxt));
    check({tag, ".depth"}, 32'(depth), 32'(e.depth));
    check({tag, ".full"},  32'(full),  32'(e.full));
    check({tag, ".empty"}, 32'(empty), 32'(e.empty));
    check({tag, ".err"},   32'(err),   32'(e.err));
  endtask

  task automatic model_op(input logic p, input logic q, input logic [WIDTH-1:0] d);
    if (p && q) begin
      if (model.size() == 0) model_err = 1'b1;
      else begin
        void'(model.pop_back());
        model.push_back(d);
      end
    end else if (p) begin
      if (model.size() == DEPTH) model_err = 1'b1;
      else model.push_back(d);
    end else if (q) begin
      if (model.size() == 0) model_err = 1'b1;
      else void'(model.pop_back());
    end
  endtask

  task automatic step(input string tag, input logic p, input logic q, input logic [WIDTH-1:0] d);
    @(negedge CLK);
    push = p;
    pop  = q;
    din  = d;
    model_op(p, q, d);
    sb.push_back(predict());
    @(posedge CLK);
    #1;
    compare(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    model.delete();
    model_err = 1'b0;
    sb.push_back(predict());
    #1;
    compare(tag);
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    model_err = 1'b0;

    do_reset("reset0");

    step("push1", 1, 0, 16'h1111);
    step("push2", 1, 0, 16'h2222);
    step("push3", 1, 0, 16'h3333);
    step("replace", 1, 1, 16'hABCD);
    step("pop_a", 0, 1, 16'h0000);
    step("idle", 0, 0, 16'h5A5A);

    do_reset("reset_full");
    for (int i = 0; i < DEPTH; i++)
      step($sformatf("fill%0d", i), 1, 0, WIDTH'(16'h1000 + i * 16'h0111));
    step("overflow", 1, 0, 16'hFFFF);
    step("repl_full", 1, 1, 16'hBEEF);
    step("pop_after_err", 0, 1, 16'h0000);
    step("push_after_err", 1, 0, 16'h7777);

    do_reset("reset_under");
    step("pop_empty", 0, 1, 16'h0000);
    do_reset("reset_under2");
    step("pushpop_empty", 1, 1, 16'h4444);

    do_reset("reset_mask");
    step("one_push", 1, 0, 16'hC0DE);
    step("pop_to_empty", 0, 1, 16'h0000);
    step("push_again", 1, 0, 16'h0123);

    do_reset("reset_mid");
    for (int i = 0; i < 5; i++)
      step($sformatf("pre%0d", i), 1, 0, WIDTH'(16'h0A00 + i));
    @(negedge CLK);
    push = 1'b1;
    pop  = 1'b0;
    din  = 16'h5555;
    #2;
    rst_n = 1'b0;
    model.delete();
    model_err = 1'b0;
    sb.push_back(predict());
    #1;
    compare("async_reset");
    sb.push_back(predict());
    @(posedge CLK);
    #1;
    compare("reset_blocks_push");
    @(negedge CLK);
    push  = 1'b0;
    rst_n = 1'b1;
    step("post_reset_push", 1, 0, 16'h9999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
